// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the debounce bank: the per-channel state encoding
// and the default values of the bank parameters.
// -----------------------------------------------------------------------------
package debounce_pkg;

    // Per-channel debounce state. The IDLE_* states hold an accepted level.
    // The PEND_* states count samples that agree with a candidate new level.
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        PEND_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        PEND_LOW  = 2'd3
    } chan_state_t;

    localparam int DEF_CHANNELS       = 4;
    localparam int DEF_STABLE_SAMPLES = 4;
    localparam int DEF_DIV_WIDTH      = 8;

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One debounced input. The raw input passes through a 2-flop synchronizer.
// A four-state FSM then accepts a new level only after STABLE_SAMPLES
// consecutive equal samples. Samples are taken on tick cycles only.
//
// Ports
//   clk    : clock, all logic on the rising edge
//   reset  : synchronous, active-high; clears every flop, FSM to IDLE_LOW
//   tick   : sample strobe; state and counter advance only when high
//   din    : raw asynchronous input
//   level  : debounced level (registered)
//   rise   : one-cycle pulse in the first cycle of a new high level
//   fall   : one-cycle pulse in the first cycle of a new low level
// -----------------------------------------------------------------------------
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    // Sized so that the count can reach STABLE_SAMPLES without wrapping.
    localparam int            CW       = $clog2(STABLE_SAMPLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_DONE = CW'(STABLE_SAMPLES);

    logic          sync_meta;
    logic          sync_q;
    chan_state_t   state_q;
    chan_state_t   state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          enter_high;
    logic          enter_low;
    logic          level_q;
    logic          rise_q;
    logic          fall_q;

    // Two-flop synchronizer. Nothing downstream looks at din directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so each flop samples the other's pre-edge
            // value; blocking here would collapse the chain to one stage.
            sync_meta <= din;
            sync_q    <= sync_meta;
        end
    end

    // Next-state logic. Outside tick cycles everything holds.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_high = 1'b0;
        enter_low  = 1'b0;
        cnt_inc    = cnt_q + CNT_ONE;

        if (tick) begin
            case (state_q)
                IDLE_LOW: begin
                    if (sync_q) begin
                        state_d = PEND_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
                PEND_HIGH: begin
                    if (!sync_q) begin
                        state_d = IDLE_LOW;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_DONE) begin
                        state_d    = IDLE_HIGH;
                        cnt_d      = '0;
                        enter_high = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                IDLE_HIGH: begin
                    if (!sync_q) begin
                        state_d = PEND_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end
                PEND_LOW: begin
                    if (sync_q) begin
                        state_d = IDLE_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_DONE) begin
                        state_d   = IDLE_LOW;
                        cnt_d     = '0;
                        enter_low = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter, level and pulse registers. The level and the pulse
    // update on the same edge, so a pulse lines up with the first cycle of
    // the new level. Pulses are rewritten every clock, so each lasts one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= enter_high;
            fall_q  <= enter_low;
            if (enter_high) begin
                level_q <= 1'b1;
            end else if (enter_low) begin
                level_q <= 1'b0;
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
// A bank of CHANNELS independent debounced inputs. All channels share one
// programmable sample strobe.
//
// Ports
//   i_w_clk     : clock, all logic on the rising edge
//   i_w_reset   : synchronous, active-high reset
//   i_w_divider : sample period is i_w_divider+1 clocks; 0 freezes the bank
//   i_w_in      : raw asynchronous inputs, one bit per channel
//   o_w_level   : debounced level per channel
//   o_w_rise    : one-cycle pulse per channel on a 0->1 level change
//   o_w_fall    : one-cycle pulse per channel on a 1->0 level change
//   o_w_tick    : sample strobe, exposed for debug
// -----------------------------------------------------------------------------
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int CHANNELS       = DEF_CHANNELS,
    parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
    parameter int DIV_WIDTH      = DEF_DIV_WIDTH
) (
    input  logic                 i_w_clk,
    input  logic                 i_w_reset,
    input  logic [DIV_WIDTH-1:0] i_w_divider,
    input  logic [CHANNELS-1:0]  i_w_in,
    output logic [CHANNELS-1:0]  o_w_level,
    output logic [CHANNELS-1:0]  o_w_rise,
    output logic [CHANNELS-1:0]  o_w_fall,
    output logic                 o_w_tick
);

    logic [DIV_WIDTH-1:0] div_cnt_q;
    logic                 tick_q;
    logic                 div_on;
    logic                 tick_en;

    assign div_on = (i_w_divider != '0);

    // The >= compare makes a divider lowered below the running count
    // fire on the next clock instead of wrapping the counter.
    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else if (!div_on) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else if (div_cnt_q >= i_w_divider) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_q + DIV_WIDTH'(1);
            tick_q    <= 1'b0;
        end
    end

    // tick_q can still be high for the cycle in which the divider drops to 0.
    // Gating it keeps the channels frozen from that cycle on.
    assign tick_en  = tick_q & div_on;
    assign o_w_tick = tick_en;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        debounce_channel #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_chan (
            .clk   (i_w_clk),
            .reset (i_w_reset),
            .tick  (tick_en),
            .din   (i_w_in[g]),
            .level (o_w_level[g]),
            .rise  (o_w_rise[g]),
            .fall  (o_w_fall[g])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// -----------------------------------------------------------------------------
// tb_debounce_bank
// Self-checking bench for debounce_bank (4 channels, 4 stable samples).
// A reference model tracks each channel as an accepted level plus the run
// length of consecutive ticks that disagree with it. The bench compares
// the DUT to this model every cycle and adds directed scenario checks.
// -----------------------------------------------------------------------------
module tb_debounce_bank;

    localparam int CH = 4;
    localparam int SS = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] divider;
    logic [CH-1:0] din;
    logic [CH-1:0] level;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic          tick;

    always #5 clk = ~clk;

    debounce_bank #(
        .CHANNELS      (CH),
        .STABLE_SAMPLES(SS),
        .DIV_WIDTH     (DW)
    ) dut (
        .i_w_clk    (clk),
        .i_w_reset  (reset),
        .i_w_divider(divider),
        .i_w_in     (din),
        .o_w_level  (level),
        .o_w_rise   (rise),
        .o_w_fall   (fall),
        .o_w_tick   (tick)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [CH-1:0] m_s1;
    logic [CH-1:0] m_s2;
    logic [CH-1:0] m_level;
    logic [CH-1:0] m_rise;
    logic [CH-1:0] m_fall;
    int            m_run [CH];
    int            m_dcnt;
    bit            m_tick;

    // Advances the model across one rising edge, using the pre-edge inputs.
    function automatic void model_edge();
        bit tick_eff;
        if (reset) begin
            m_s1    = '0;
            m_s2    = '0;
            m_level = '0;
            m_rise  = '0;
            m_fall  = '0;
            m_dcnt  = 0;
            m_tick  = 1'b0;
            for (int c = 0; c < CH; c++) m_run[c] = 0;
        end else begin
            tick_eff = m_tick && (divider != '0);
            m_rise   = '0;
            m_fall   = '0;
            if (tick_eff) begin
                for (int c = 0; c < CH; c++) begin
                    if (m_s2[c] != m_level[c]) begin
                        m_run[c]++;
                        if (m_run[c] == SS) begin
                            m_level[c] = ~m_level[c];
                            if (m_level[c]) m_rise[c] = 1'b1;
                            else            m_fall[c] = 1'b1;
                            m_run[c] = 0;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
            end
            if (divider == '0) begin
                m_dcnt = 0;
                m_tick = 1'b0;
            end else if (m_dcnt >= int'(divider)) begin
                m_dcnt = 0;
                m_tick = 1'b1;
            end else begin
                m_dcnt++;
                m_tick = 1'b0;
            end
            m_s2 = m_s1;
            m_s1 = din;
        end
    endfunction

    // ---------------- tallies of observed DUT activity ----------------
    int cyc = 0;
    int ticks_used;
    int rise_cnt [CH];
    int fall_cnt [CH];
    int rise_cyc [CH];
    int fall_cyc [CH];

    task automatic clear_tally();
        ticks_used = 0;
        for (int c = 0; c < CH; c++) begin
            rise_cnt[c] = 0;
            fall_cnt[c] = 0;
            rise_cyc[c] = -1;
            fall_cyc[c] = -1;
        end
    endtask

    // One clock: advance the model, cross the edge, compare 1 time unit later.
    task automatic step();
        if (tick === 1'b1) ticks_used++;
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check("level", 32'(level), 32'(m_level));
        check("rise",  32'(rise),  32'(m_rise));
        check("fall",  32'(fall),  32'(m_fall));
        check("tick",  32'(tick),  32'(m_tick && (divider != '0)));
        for (int c = 0; c < CH; c++) begin
            if (rise[c] === 1'b1) begin
                rise_cnt[c]++;
                rise_cyc[c] = cyc;
            end
            if (fall[c] === 1'b1) begin
                fall_cnt[c]++;
                fall_cyc[c] = cyc;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Steps until the current cycle is a tick cycle, then consumes that tick.
    // Inputs changed afterwards are sampled on exactly the 4th tick.
    task automatic align_tick();
        int k = 0;
        while (tick !== 1'b1 && k < 32) begin
            step();
            k++;
        end
        check("align_tick", 32'(tick), 32'(1));
        step();
    endtask

    task automatic wait_level(input int c, input logic v, input string tag);
        int k = 0;
        while (level[c] !== v && k < 200) begin
            step();
            k++;
        end
        check(tag, 32'(level[c]), 32'(v));
    endtask

    task automatic wait_ticks(input int n);
        int k = 0;
        while (ticks_used < n && k < 64) begin
            step();
            k++;
        end
        check("wait_ticks", 32'(ticks_used), 32'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    logic [CH-1:0] lvl_before;

    initial begin
        clear_tally();
        reset   = 1'b1;
        divider = DW'(3);
        din     = '1;

        // Reset held 5 clocks with all inputs high.
        run(5);
        check("rst_level", 32'(level), 32'(0));
        check("rst_rise",  32'(rise),  32'(0));
        check("rst_fall",  32'(fall),  32'(0));
        check("rst_tick",  32'(tick),  32'(0));

        reset = 1'b0;
        clear_tally();
        wait_level(0, 1'b1, "r031_accept");
        check("r031_level", 32'(level), 32'(4'hF));
        check("r031_ticks", 32'(ticks_used), 32'(4));
        run(3);
        for (int c = 0; c < CH; c++)
            check($sformatf("r031_rise_cnt%0d", c), 32'(rise_cnt[c]), 32'(1));

        // Bring everything low again.
        din = '0;
        wait_level(0, 1'b0, "settle_low");
        run(3);

        // Clean single edge on ch0.
        align_tick();
        din[0] = 1'b1;
        clear_tally();
        wait_level(0, 1'b1, "r032_accept");
        check("r032_ticks", 32'(ticks_used), 32'(4));
        run(6);
        check("r032_rise_cnt", 32'(rise_cnt[0]), 32'(1));
        check("r032_fall_cnt", 32'(fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3]), 32'(0));
        check("r032_others", 32'(level[3:1]), 32'(0));

        // Bounce on ch1: toggle every 6 clocks for 60 clocks, then settle high.
        clear_tally();
        run(int'($urandom_range(0, 3)));
        for (int t = 0; t < 10; t++) begin
            din[1] = ~din[1];
            run(6);
        end
        check("r033_bounce_rise", 32'(rise_cnt[1]), 32'(0));
        check("r033_bounce_fall", 32'(fall_cnt[1]), 32'(0));
        check("r033_bounce_level", 32'(level[1]), 32'(0));
        din[1] = 1'b1;
        wait_level(1, 1'b1, "r033_accept");
        run(6);
        check("r033_rise_cnt", 32'(rise_cnt[1]), 32'(1));

        // Freeze with ch2 two ticks into a pending rise.
        align_tick();
        din[2] = 1'b1;
        clear_tally();
        wait_ticks(2);
        divider    = '0;
        lvl_before = level;
        clear_tally();
        for (int i = 0; i < 100; i++) begin
            din = CH'($urandom);
            step();
        end
        check("r034_ticks", 32'(ticks_used), 32'(0));
        check("r034_level", 32'(level), 32'(lvl_before));
        check("r034_pulses", 32'(rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3]
                                 + fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3]), 32'(0));
        din = 4'b0111;
        run(3);
        divider = DW'(3);
        clear_tally();
        wait_level(2, 1'b1, "r034_accept");
        check("r034_resume_ticks", 32'(ticks_used), 32'(2));
        run(4);

        // Reset while ch2 is two ticks into a pending rise.
        din[2] = 1'b0;
        wait_level(2, 1'b0, "r035_settle_low");
        run(3);
        align_tick();
        din[2] = 1'b1;
        clear_tally();
        wait_ticks(2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("r035_rst_level", 32'(level), 32'(0));
        clear_tally();
        wait_level(2, 1'b1, "r035_accept");
        check("r035_ticks", 32'(ticks_used), 32'(4));
        run(4);

        // Simultaneous fall on ch0 and rise on ch3.
        din[0] = 1'b0;
        din[3] = 1'b1;
        clear_tally();
        wait_level(3, 1'b1, "r036_accept");
        run(4);
        check("r036_rise_cnt", 32'(rise_cnt[3]), 32'(1));
        check("r036_fall_cnt", 32'(fall_cnt[0]), 32'(1));
        check("r036_same_cycle", 32'(fall_cyc[0]), 32'(rise_cyc[3]));
        check("r036_level", 32'(level), 32'(4'b1110));

        // Random phase: random inputs, hold times, dividers and resets.
        for (int seg = 0; seg < 40; seg++) begin
            if ($urandom_range(0, 7) == 0) divider = DW'($urandom_range(0, 5));
            if ($urandom_range(0, 15) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
            din = CH'($urandom);
            run(int'($urandom_range(1, 30)));
        end
        divider = DW'(3);
        run(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, giving the number of independent input channels (1..32).
REQ-002 The block SHALL have parameter STABLE_SAMPLES, default 4, giving the consecutive equal samples needed to accept a change (2..255).
REQ-003 The block SHALL have parameter DIV_WIDTH, default 8, giving the width of the sample-divider input.
REQ-004 The block SHALL have port i_w_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port i_w_reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port i_w_divider, input, DIV_WIDTH bits: sample period is i_w_divider+1 clocks; 0 disables sampling.
REQ-007 The block SHALL have port i_w_in, input, CHANNELS bits: raw asynchronous bouncy inputs.
REQ-008 The block SHALL have port o_w_level, output, CHANNELS bits: debounced level per channel.
REQ-009 The block SHALL have port o_w_rise, output, CHANNELS bits: one-cycle pulse when a level goes 0->1.
REQ-010 The block SHALL have port o_w_fall, output, CHANNELS bits: one-cycle pulse when a level goes 1->0.
REQ-011 The block SHALL have port o_w_tick, output, 1 bit: the sample strobe, exposed for debug.

Function
REQ-012 The block SHALL pass each i_w_in bit through a 2-flop synchronizer; all logic after it uses only the synchronized value.
REQ-013 The block SHALL run a divider counter that increments every clock.
  - When counter >= i_w_divider and i_w_divider != 0: assert tick for one clock and clear the counter.
  - A divider value changed mid-count SHALL take effect immediately under the same >= rule.
REQ-014 With i_w_divider == 0, the divider counter SHALL hold at 0, tick SHALL stay 0, and every channel SHALL freeze its state, counter and level.
REQ-015 Each channel SHALL implement a four-state machine: IDLE_LOW, PEND_HIGH, IDLE_HIGH, PEND_LOW.
REQ-016 The channel state and its stability counter SHALL change only on tick cycles.
REQ-017 IDLE_LOW SHALL move to PEND_HIGH with count=1 on a tick sampling 1; otherwise it stays.
REQ-018 PEND_HIGH SHALL behave as follows on a tick:
  - Sample 1: increment count.
  - Count reaches STABLE_SAMPLES: go to IDLE_HIGH and clear count.
  - Sample 0: return to IDLE_LOW and clear count.
REQ-019 IDLE_HIGH and PEND_LOW SHALL mirror REQ-017 and REQ-018 with the polarities swapped.
REQ-020 o_w_level SHALL be a register set in the same clock edge the state enters IDLE_HIGH and cleared when it enters IDLE_LOW from PEND_LOW.
REQ-021 o_w_rise and o_w_fall SHALL be registered pulses, high exactly during the clock cycle after that edge, coincident with the first cycle of the new level.
REQ-022 Latency SHALL be as follows:
  - A clean input change is accepted on the STABLE_SAMPLES-th tick after the synchronized value changes.
  - Synchronizer delay is 2 clocks.
REQ-023 Channels SHALL be fully independent; simultaneous changes on several channels SHALL produce their pulses in the same cycle.
REQ-024 The stability counter SHALL be $clog2(STABLE_SAMPLES+1) bits wide and SHALL never wrap.

Reset
REQ-025 While i_w_reset is high at a clock edge, the block SHALL clear to zero all of the following: synchronizer flops, divider counter, tick, stability counters, o_w_level, o_w_rise and o_w_fall; all states SHALL be set to IDLE_LOW.
REQ-026 Reset asserted mid-operation SHALL discard any pending count; after release, a channel needs a full STABLE_SAMPLES ticks again.
REQ-027 Reset SHALL take priority over tick.

Structure
REQ-028 Package debounce_pkg SHALL hold the channel state encoding (2-bit) and the default parameter constants.
REQ-029 A sub-module debounce_channel SHALL contain the synchronizer, the FSM, the counter and the pulse registers, and SHALL be instantiated CHANNELS times via generate.
REQ-030 The top level SHALL contain only the divider/tick logic and the channel instances.

Verification (CHANNELS=4, STABLE_SAMPLES=4, i_w_divider=3, i.e. a tick every 4 clocks)
REQ-031 Reset: hold reset 5 clocks with i_w_in=4'hF -> level, rise and fall are all 0 and tick is 0; after release, level[3:0] becomes 4'hF after the 4th tick, with a rise pulse of 4'hF for one cycle.
REQ-032 Clean edge: ch0 goes 0->1 and is held -> level[0] rises on the 4th tick after sync; rise[0] is high exactly 1 cycle; fall stays 0; other channels are unchanged.
REQ-033 Bounce: ch1 toggles every 6 clocks for 60 clocks, then settles at 1 -> no level or pulse change during the bounce; exactly one rise[1] after 4 stable ticks.
REQ-034 Disabled: set divider 0 and toggle all inputs for 100 clocks -> tick stays 0 and outputs are unchanged; restoring divider 3 resumes from the frozen counts.
REQ-035 Reset mid-operation: assert reset for 1 clock while ch2 is in PEND_HIGH with count=2, keeping the input at 1 -> level[2] rises only after 4 further ticks.
REQ-036 Simultaneous: with ch0 high and ch3 low, drop ch0 and raise ch3 in the same cycle -> fall[0] and rise[3] pulse in the same cycle.
